gerador_paridade_tx: RTL

- Transmit end of the 5-bit + parity word link; `verificador_paridade` is the checking end.
- Accepts a 5-bit word (b1..b5) through a send/ready handshake and computes its parity bit bp.
- Serialises start bit, b1..b5, bp and stop bit on a single line, each bit held for a programmable number of clocks.
- Feeds the serial-to-parallel front end of the verifier path.

---
 rtl/gerador_paridade_tx_pkg.sv | 15 +
 rtl/gerador_paridade_tx_if.sv | 25 ++
 rtl/gerador_paridade_tx_calc_paridade.sv | 16 +
 rtl/gerador_paridade_tx.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/gerador_paridade_tx_pkg.sv
// Shared definitions for the 5-bit + parity word link (transmitter and verifier).
package gerador_paridade_tx_pkg;

    localparam int unsigned BITS_QUADRO = 8;
    localparam int unsigned BITS_DADOS  = 5;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        INICIO   = 3'd1,
        DADOS    = 3'd2,
        PARIDADE = 3'd3,
        PARADA   = 3'd4
    } estado_t;

endpackage

// File: rtl/gerador_paridade_tx_if.sv
// Word/handshake and serial-line bundle between a word source and the transmitter.
interface gerador_paridade_tx_if;

    logic envia;
    logic b1;
    logic b2;
    logic b3;
    logic b4;
    logic b5;
    logic pronto;
    logic tx;
    logic bp;
    logic fim;

    modport master (
        output envia, b1, b2, b3, b4, b5,
        input  pronto, tx, bp, fim
    );

    modport slave (
        input  envia, b1, b2, b3, b4, b5,
        output pronto, tx, bp, fim
    );

endinterface

// File: rtl/gerador_paridade_tx_calc_paridade.sv
// Combinational parity of a data word; shared by transmit and verify paths.
module calc_paridade
    import gerador_paridade_tx_pkg::*;
#(
    parameter int unsigned PARIDADE_IMPAR = 0
) (
    input  logic [BITS_DADOS-1:0] dados_i,
    output logic                  paridade_o
);

    // XOR reduction, inverted for odd parity
    always_comb begin
        paridade_o = (^dados_i) ^ 1'(PARIDADE_IMPAR);
    end

endmodule

// File: rtl/gerador_paridade_tx.sv
// Serial transmitter: start bit, b1..b5, parity, stop bit, each held CICLOS_POR_BIT clocks.
module gerador_paridade_tx
    import gerador_paridade_tx_pkg::*;
#(
    parameter int unsigned CICLOS_POR_BIT = 4,
    parameter int unsigned PARIDADE_IMPAR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    gerador_paridade_tx_if.slave bus
);

    localparam int unsigned    CW      = $clog2(CICLOS_POR_BIT + 1);
    localparam logic [CW-1:0]  ULTIMO  = CW'(CICLOS_POR_BIT - 1);
    localparam logic [2:0]     BIT_MAX = 3'(BITS_DADOS - 1);

    estado_t               state_q, state_d;
    logic [CW-1:0]         cnt_ciclo_q, cnt_ciclo_d;
    logic [2:0]            cnt_bit_q, cnt_bit_d;
    logic [BITS_DADOS-1:0] shift_q, shift_d;
    logic                  bp_q, bp_d;
    logic                  tx_q, tx_d;
    logic                  fim_q, fim_d;

    logic [BITS_DADOS-1:0] dados_c;
    logic                  par_c;
    logic                  fim_bit_c;

    // b1 sits at the LSB so the shift register emits it first
    assign dados_c = {bus.b5, bus.b4, bus.b3, bus.b2, bus.b1};

    calc_paridade #(
        .PARIDADE_IMPAR (PARIDADE_IMPAR)
    ) u_calc_paridade (
        .dados_i    (dados_c),
        .paridade_o (par_c)
    );

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= OCIOSO;
            cnt_ciclo_q <= '0;
            cnt_bit_q   <= '0;
            shift_q     <= '0;
            bp_q        <= 1'b0;
            tx_q        <= 1'b1;
            fim_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_ciclo_q <= cnt_ciclo_d;
            cnt_bit_q   <= cnt_bit_d;
            shift_q     <= shift_d;
            bp_q        <= bp_d;
            tx_q        <= tx_d;
            fim_q       <= fim_d;
        end
    end

    // Next-state and output decode; tx/fim are derived from the next state so
    // they line up with the state they describe
    always_comb begin
        state_d     = state_q;
        cnt_ciclo_d = cnt_ciclo_q;
        cnt_bit_d   = cnt_bit_q;
        shift_d     = shift_q;
        bp_d        = bp_q;
        tx_d        = 1'b1;
        fim_d       = 1'b0;
        fim_bit_c   = (cnt_ciclo_q == ULTIMO);

        case (state_q)
            OCIOSO: begin
                if (bus.envia) begin
                    state_d     = INICIO;
                    cnt_ciclo_d = '0;
                    cnt_bit_d   = '0;
                    shift_d     = dados_c;
                    bp_d        = par_c;
                end
            end
            INICIO: begin
                if (fim_bit_c) begin
                    cnt_ciclo_d = '0;
                    state_d     = DADOS;
                end else begin
                    cnt_ciclo_d = cnt_ciclo_q + CW'(1);
                end
            end
            DADOS: begin
                if (fim_bit_c) begin
                    cnt_ciclo_d = '0;
                    shift_d     = shift_q >> 1;
                    if (cnt_bit_q == BIT_MAX) begin
                        cnt_bit_d = '0;
                        state_d   = PARIDADE;
                    end else begin
                        cnt_bit_d = cnt_bit_q + 3'd1;
                    end
                end else begin
                    cnt_ciclo_d = cnt_ciclo_q + CW'(1);
                end
            end
            PARIDADE: begin
                if (fim_bit_c) begin
                    cnt_ciclo_d = '0;
                    state_d     = PARADA;
                end else begin
                    cnt_ciclo_d = cnt_ciclo_q + CW'(1);
                end
            end
            PARADA: begin
                if (fim_bit_c) begin
                    cnt_ciclo_d = '0;
                    state_d     = OCIOSO;
                end else begin
                    cnt_ciclo_d = cnt_ciclo_q + CW'(1);
                end
            end
            default: begin
                state_d     = OCIOSO;
                cnt_ciclo_d = '0;
                cnt_bit_d   = '0;
            end
        endcase

        case (state_d)
            INICIO:   tx_d = 1'b0;
            DADOS:    tx_d = shift_d[0];
            PARIDADE: tx_d = bp_d;
            default:  tx_d = 1'b1;
        endcase

        fim_d = (state_d == PARADA) && (cnt_ciclo_d == ULTIMO);
    end

    assign bus.pronto = (state_q == OCIOSO);
    assign bus.tx     = tx_q;
    assign bus.bp     = bp_q;
    assign bus.fim    = fim_q;

endmodule
